// File: rtl/flow_scheduler_pkg.sv
// Flow-unit types, NOP bundle, scheduler entry layout and FSM state codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flow_scheduler_pkg;

    localparam int FLOW_TAG_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        FLOW_NOP    = 2'd0,
        FLOW_JAL    = 2'd1,
        FLOW_JALR   = 2'd2,
        FLOW_BRANCH = 2'd3
    } FLOW_FUNC;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6
    } BRANCH_TYPE;

    typedef struct packed {
        FLOW_FUNC         flow_func;
        BRANCH_TYPE       branch_type;
        logic [XLEN-1:0]  pc_lhs;
        logic [XLEN-1:0]  pc_rhs;
        logic [XLEN-1:0]  branch_lhs;
        logic [XLEN-1:0]  branch_rhs;
    } INSTRUCTION_FLOW;

    typedef struct packed {
        logic [FLOW_TAG_W-1:0] dest;
        logic [XLEN-1:0]       data;
    } RESULT;

    typedef struct packed {
        INSTRUCTION_FLOW       instr;
        logic [FLOW_TAG_W-1:0] tag1;
        logic [FLOW_TAG_W-1:0] tag2;
        logic                  rdy1;
        logic                  rdy2;
    } FLOW_SCHED_ENTRY;

    localparam INSTRUCTION_FLOW FLOW_NOP_BUNDLE = '{
        flow_func:   FLOW_NOP,
        branch_type: BR_NONE,
        pc_lhs:      '0,
        pc_rhs:      '0,
        branch_lhs:  '0,
        branch_rhs:  '0
    };

    localparam FLOW_SCHED_ENTRY FLOW_SCHED_EMPTY = '{
        instr: FLOW_NOP_BUNDLE,
        tag1:  '0,
        tag2:  '0,
        rdy1:  1'b0,
        rdy2:  1'b0
    };

    // Scheduler FSM encoding
    localparam logic [1:0] FLOW_RUN     = 2'd0;
    localparam logic [1:0] FLOW_ISSUED  = 2'd1;
    localparam logic [1:0] FLOW_RESOLVE = 2'd2;

    // A still-pending source is woken by a matching broadcast.
    function automatic logic tag_wakes(input logic snoop, input logic rdy,
                                       input logic [FLOW_TAG_W-1:0] tag,
                                       input RESULT res);
        return snoop && !rdy && (tag == res.dest);
    endfunction

endpackage

// File: rtl/flow_scheduler_if.sv
// Enqueue, result-bus, flow-unit and status signals of the flow scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on enqueue; the other signals are unthrottled.
interface flow_scheduler_if
    import flow_scheduler_pkg::*;
#(
    parameter int TAG_W = FLOW_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    INSTRUCTION_FLOW  in_instr;
    logic [TAG_W-1:0] in_src1_tag;
    logic             in_src1_rdy;
    logic [TAG_W-1:0] in_src2_tag;
    logic             in_src2_rdy;
    logic             cdb_valid;
    RESULT            cdb;
    logic             flow_jump;
    INSTRUCTION_FLOW  issue_instr;
    logic             issue_valid;
    logic             flush;
    logic             busy;

    modport master (
        output in_valid, in_instr, in_src1_tag, in_src1_rdy, in_src2_tag, in_src2_rdy,
        output cdb_valid, cdb, flow_jump,
        input  in_ready, issue_instr, issue_valid, flush, busy
    );

    modport slave (
        input  in_valid, in_instr, in_src1_tag, in_src1_rdy, in_src2_tag, in_src2_rdy,
        input  cdb_valid, cdb, flow_jump,
        output in_ready, issue_instr, issue_valid, flush, busy
    );
endinterface

// File: rtl/flow_sched_entry.sv
// One scheduler slot: holds an instruction, compares pending tags with the result bus, captures data.
// Latency: a write or wakeup is visible in entry/vld the cycle after it happens.
// Backpressure: none; the top never writes an occupied slot.
// Ports: clear invalidates (redirect), wr_* loads the slot, pop releases it, cdb_* snoops results.
module flow_sched_entry
    import flow_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic                  pop,
    input  INSTRUCTION_FLOW       wr_instr,
    input  logic [FLOW_TAG_W-1:0] wr_tag1,
    input  logic                  wr_rdy1,
    input  logic [FLOW_TAG_W-1:0] wr_tag2,
    input  logic                  wr_rdy2,
    input  logic                  cdb_valid,
    input  RESULT                 cdb,
    output logic                  vld,
    output FLOW_SCHED_ENTRY       entry
);
    FLOW_SCHED_ENTRY nxt;
    logic            snoop;

    // A slot being written snoops too, so a same-cycle broadcast is not lost.
    // A slot being popped ignores the bus: its issue copy was already taken.
    assign snoop = cdb_valid && (wr_en || (vld && !pop));

    always_comb begin
        nxt = entry;
        if (wr_en) begin
            nxt.instr = wr_instr;
            nxt.tag1  = wr_tag1;
            nxt.tag2  = wr_tag2;
            // Tag 0 has no producer and is always ready.
            nxt.rdy1  = wr_rdy1 || (wr_tag1 == '0);
            nxt.rdy2  = wr_rdy2 || (wr_tag2 == '0);
        end
        if (tag_wakes(snoop, nxt.rdy1, nxt.tag1, cdb)) begin
            nxt.rdy1             = 1'b1;
            nxt.instr.branch_lhs = cdb.data;
            if (nxt.instr.flow_func == FLOW_JALR) begin
                nxt.instr.pc_lhs = cdb.data;
            end
        end
        if (tag_wakes(snoop, nxt.rdy2, nxt.tag2, cdb)) begin
            nxt.rdy2             = 1'b1;
            nxt.instr.branch_rhs = cdb.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld   <= 1'b0;
            entry <= FLOW_SCHED_EMPTY;
        end else if (clear) begin
            vld   <= 1'b0;
        end else begin
            vld   <= wr_en || (vld && !pop);
            entry <= nxt;
        end
    end
endmodule

// File: rtl/flow_scheduler.sv
// In-order issue queue for the flow unit: one issue at a time, held until the redirect resolves.
// Latency: an entry ready at the head issues one cycle later; issue-to-issue spacing is 3 cycles.
// Backpressure: in_ready drops when the queue is full or during a redirect flush.
// Ports: clk, reset (sync, active-low), bus (flow_scheduler_if.slave) carrying enqueue, cdb, flow_jump, issue and status.
module flow_scheduler
    import flow_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = FLOW_TAG_W
)
(
    input  logic             clk,
    input  logic             reset,
    flow_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [1:0]       state;
    INSTRUCTION_FLOW  issue_instr_q;
    logic             issue_valid_q;

    FLOW_SCHED_ENTRY  ent [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    FLOW_SCHED_ENTRY  head_ent;
    logic             flush;
    logic             full;
    logic             push;
    logic             pop;

    assign flush        = (state == FLOW_RESOLVE) && bus.flow_jump;
    assign full         = (count == PTR_W'(DEPTH));
    assign bus.in_ready = !full && !flush;
    assign push         = bus.in_valid && bus.in_ready;

    assign head_ent = ent[head[IDX_W-1:0]];
    // Ready bits are registered, so a wakeup this cycle issues no earlier than next cycle.
    assign pop = (state == FLOW_RUN) && (count != '0) && ent_vld[head[IDX_W-1:0]]
                 && head_ent.rdy1 && head_ent.rdy2;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        flow_sched_entry u_ent (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush),
            .wr_en     (push && (tail[IDX_W-1:0] == IDX_W'(i))),
            .pop       (pop && (head[IDX_W-1:0] == IDX_W'(i))),
            .wr_instr  (bus.in_instr),
            .wr_tag1   (bus.in_src1_tag),
            .wr_rdy1   (bus.in_src1_rdy),
            .wr_tag2   (bus.in_src2_tag),
            .wr_rdy2   (bus.in_src2_rdy),
            .cdb_valid (bus.cdb_valid),
            .cdb       (bus.cdb),
            .vld       (ent_vld[i]),
            .entry     (ent[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= FLOW_RUN;
            issue_instr_q <= FLOW_NOP_BUNDLE;
            issue_valid_q <= 1'b0;
        end else begin
            // push and pop cannot coincide with flush: in_ready is low and state is RESOLVE.
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                count <= count + PTR_W'(push) - PTR_W'(pop);
            end

            case (state)
                FLOW_RUN: begin
                    if (pop) begin
                        issue_instr_q <= head_ent.instr;
                        issue_valid_q <= 1'b1;
                        state         <= FLOW_ISSUED;
                    end
                end
                FLOW_ISSUED: begin
                    issue_instr_q <= FLOW_NOP_BUNDLE;
                    issue_valid_q <= 1'b0;
                    state         <= FLOW_RESOLVE;
                end
                default: begin
                    state <= FLOW_RUN;
                end
            endcase
        end
    end

    assign bus.issue_instr = issue_instr_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.flush       = flush;
    assign bus.busy        = (count != '0) || (state != FLOW_RUN);

    // flow_p1 only reports a jump in the resolve slot.
    a_jump_in_resolve: assert property (@(posedge clk) disable iff (!reset)
        bus.flow_jump |-> (state == FLOW_RESOLVE));
endmodule

// File: tb/tb_flow_scheduler.sv
module tb_flow_scheduler;
    import flow_scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    flow_scheduler_if #(.TAG_W(5)) bus_if ();

    flow_scheduler #(.DEPTH(4), .TAG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic INSTRUCTION_FLOW mk(input FLOW_FUNC f, input BRANCH_TYPE b,
                                           input logic [31:0] pl, input logic [31:0] pr,
                                           input logic [31:0] bl, input logic [31:0] br);
        INSTRUCTION_FLOW r;
        r.flow_func   = f;
        r.branch_type = b;
        r.pc_lhs      = pl;
        r.pc_rhs      = pr;
        r.branch_lhs  = bl;
        r.branch_rhs  = br;
        return r;
    endfunction

    task automatic drive_in(input INSTRUCTION_FLOW i, input logic [4:0] t1, input logic r1,
                            input logic [4:0] t2, input logic r2);
        bus_if.in_valid    = 1'b1;
        bus_if.in_instr    = i;
        bus_if.in_src1_tag = t1;
        bus_if.in_src1_rdy = r1;
        bus_if.in_src2_tag = t2;
        bus_if.in_src2_rdy = r2;
    endtask

    task automatic drive_cdb(input logic v, input logic [4:0] d, input logic [31:0] x);
        bus_if.cdb_valid = v;
        bus_if.cdb.dest  = d;
        bus_if.cdb.data  = x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_iss;
        int last;

        reset = 1'b0;
        drive_in(mk(FLOW_BRANCH, BR_BEQ, 0, 0, 1, 1), 5'd0, 1'b1, 5'd0, 1'b1);
        drive_cdb(1'b0, 5'd0, 32'h0);
        bus_if.flow_jump = 1'b0;

        // Reset held for two cycles with in_valid high
        tick();
        tick();
        chk("rst_count", 32'(dut.count), 32'd0);
        chk("rst_issue_valid", 32'(bus_if.issue_valid), 32'd0);
        chk("rst_flow_func", 32'(bus_if.issue_instr.flow_func), 32'(FLOW_NOP));
        chk("rst_branch_type", 32'(bus_if.issue_instr.branch_type), 32'(BR_NONE));
        chk("rst_flush", 32'(bus_if.flush), 32'd0);
        reset = 1'b1;
        bus_if.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);

        // Ready BEQ, taken
        drive_in(mk(FLOW_BRANCH, BR_BEQ, 32'h40, 32'h8, 32'd5, 32'd5), 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        bus_if.in_valid = 1'b0;
        chk("beq_no_bypass", 32'(bus_if.issue_valid), 32'd0);
        chk("beq_count", 32'(dut.count), 32'd1);
        chk("beq_busy", 32'(bus_if.busy), 32'd1);
        tick();
        chk("beq_issue_valid", 32'(bus_if.issue_valid), 32'd1);
        chk("beq_func", 32'(bus_if.issue_instr.flow_func), 32'(FLOW_BRANCH));
        chk("beq_type", 32'(bus_if.issue_instr.branch_type), 32'(BR_BEQ));
        chk("beq_lhs", bus_if.issue_instr.branch_lhs, 32'd5);
        chk("beq_rhs", bus_if.issue_instr.branch_rhs, 32'd5);
        chk("beq_popped", 32'(dut.count), 32'd0);
        chk("beq_no_flush_issued", 32'(bus_if.flush), 32'd0);
        tick();
        chk("beq_nop_after", 32'(bus_if.issue_valid), 32'd0);
        chk("beq_nop_func", 32'(bus_if.issue_instr.flow_func), 32'(FLOW_NOP));
        bus_if.flow_jump = 1'b1;
        #1;
        chk("beq_flush", 32'(bus_if.flush), 32'd1);
        chk("beq_in_ready_flush", 32'(bus_if.in_ready), 32'd0);
        tick();
        bus_if.flow_jump = 1'b0;
        #1;
        chk("beq_busy_after", 32'(bus_if.busy), 32'd0);
        chk("beq_flush_pulse", 32'(bus_if.flush), 32'd0);

        // BNE waiting on tag 7
        drive_in(mk(FLOW_BRANCH, BR_BNE, 32'h80, 32'h10, 32'h0, 32'h20), 5'd7, 1'b0, 5'd0, 1'b1);
        tick();
        bus_if.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bne_wait", 32'(bus_if.issue_valid), 32'd0);
            tick();
        end
        drive_cdb(1'b1, 5'd7, 32'h10);
        tick();
        drive_cdb(1'b0, 5'd0, 32'h0);
        chk("bne_wake_no_bypass", 32'(bus_if.issue_valid), 32'd0);
        tick();
        chk("bne_issue_valid", 32'(bus_if.issue_valid), 32'd1);
        chk("bne_type", 32'(bus_if.issue_instr.branch_type), 32'(BR_BNE));
        chk("bne_lhs", bus_if.issue_instr.branch_lhs, 32'h10);
        chk("bne_rhs", bus_if.issue_instr.branch_rhs, 32'h20);
        tick();
        tick();
        chk("bne_busy_after", 32'(bus_if.busy), 32'd0);

        // JALR whose src1 producer broadcasts in the enqueue cycle; src2 tag 0
        drive_in(mk(FLOW_JALR, BR_NONE, 32'h0, 32'h4, 32'h0, 32'h0), 5'd9, 1'b0, 5'd0, 1'b0);
        drive_cdb(1'b1, 5'd9, 32'h400);
        tick();
        bus_if.in_valid = 1'b0;
        drive_cdb(1'b0, 5'd0, 32'h0);
        tick();
        chk("jalr_issue_valid", 32'(bus_if.issue_valid), 32'd1);
        chk("jalr_func", 32'(bus_if.issue_instr.flow_func), 32'(FLOW_JALR));
        chk("jalr_pc_lhs", bus_if.issue_instr.pc_lhs, 32'h400);
        chk("jalr_br_lhs", bus_if.issue_instr.branch_lhs, 32'h400);
        chk("jalr_pc_rhs", bus_if.issue_instr.pc_rhs, 32'h4);
        tick();
        tick();

        // Fill four non-ready entries, fifth is lost
        for (int k = 0; k < 5; k++) begin
            drive_in(mk(FLOW_BRANCH, BR_BLT, 32'h0, 32'h0, 32'h0, 32'h0), 5'(11 + k), 1'b0, 5'd0, 1'b1);
            tick();
        end
        bus_if.in_valid = 1'b0;
        chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("full_count", 32'(dut.count), 32'd4);
        chk("full_no_issue", 32'(bus_if.issue_valid), 32'd0);
        n_iss = 0;
        last = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 5) drive_cdb(1'b1, 5'(11 + k), 32'hA1 + 32'(k));
            else       drive_cdb(1'b0, 5'd0, 32'h0);
            tick();
            if (bus_if.issue_valid) begin
                chk("fill_lhs", bus_if.issue_instr.branch_lhs, 32'hA1 + 32'(n_iss));
                if (n_iss > 0) chk("fill_spacing", 32'(k - last), 32'd3);
                last = k;
                n_iss++;
            end
        end
        chk("fill_issued", 32'(n_iss), 32'd4);
        chk("fill_busy", 32'(bus_if.busy), 32'd0);

        // Two ready JALs; the younger is squashed by the redirect
        drive_in(mk(FLOW_JAL, BR_NONE, 32'h0, 32'h100, 32'h0, 32'h0), 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        drive_in(mk(FLOW_JAL, BR_NONE, 32'h0, 32'h200, 32'h0, 32'h0), 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        bus_if.in_valid = 1'b0;
        chk("jal_issue_valid", 32'(bus_if.issue_valid), 32'd1);
        chk("jal_pc_rhs", bus_if.issue_instr.pc_rhs, 32'h100);
        chk("jal_count", 32'(dut.count), 32'd1);
        tick();
        bus_if.flow_jump = 1'b1;
        drive_in(mk(FLOW_JAL, BR_NONE, 32'h0, 32'h300, 32'h0, 32'h0), 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        chk("jal_flush", 32'(bus_if.flush), 32'd1);
        chk("jal_in_ready_flush", 32'(bus_if.in_ready), 32'd0);
        tick();
        bus_if.flow_jump = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("jal_flushed_count", 32'(dut.count), 32'd0);
        chk("jal_flushed_busy", 32'(bus_if.busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("jal_squashed_no_issue", 32'(bus_if.issue_valid), 32'd0);
        end

        // Reset while in ISSUED with a queued entry behind it
        drive_in(mk(FLOW_BRANCH, BR_BGE, 32'h0, 32'h0, 32'd1, 32'd2), 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        drive_in(mk(FLOW_BRANCH, BR_BNE, 32'h0, 32'h0, 32'h0, 32'h0), 5'd20, 1'b0, 5'd0, 1'b1);
        tick();
        bus_if.in_valid = 1'b0;
        chk("midrst_issued", 32'(bus_if.issue_valid), 32'd1);
        chk("midrst_count_before", 32'(dut.count), 32'd1);
        reset = 1'b0;
        tick();
        chk("midrst_state", 32'(dut.state), 32'(FLOW_RUN));
        chk("midrst_issue_valid", 32'(bus_if.issue_valid), 32'd0);
        chk("midrst_flow_func", 32'(bus_if.issue_instr.flow_func), 32'(FLOW_NOP));
        chk("midrst_lhs", bus_if.issue_instr.branch_lhs, 32'd0);
        chk("midrst_count", 32'(dut.count), 32'd0);
        chk("midrst_busy", 32'(bus_if.busy), 32'd0);
        reset = 1'b1;
        tick();
        chk("midrst_after_release", 32'(bus_if.issue_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
